// File: rtl/div_unit_if.sv
// div_unit_if: operand/result bundle between the EX-stage issue logic and the
// multi-cycle divider.
//   a, b        32-bit dividend (rs) and divisor (rt)
//   signed_div  1 = DIV, 0 = DIVU
//   start       divide request, only honoured while the divider is idle
//   annul       exception flush, abandons whatever the divider is doing
//   result      {remainder, quotient} for the HI/LO write path
//   busy        divide in progress, stalls the pipeline
//   ready       one-cycle pulse marking result as valid
// master: issue side (decoder / testbench); slave: the divider.
interface div_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_div;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        busy;
  logic        ready;

  modport master (
    output a, b, signed_div, start, annul,
    input  result, busy, ready
  );

  modport slave (
    input  a, b, signed_div, start, annul,
    output result, busy, ready
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit restoring radix-2 divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle; 33 cycles from an accepted start to ready.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   dif  div_unit_if.slave (a, b, signed_div, start, annul in;
//        result, busy, ready out)
// Build option: define DIV_SIGNED_EN to enable signed DIV (magnitude
// conversion at start plus sign correction of quotient/remainder). Without
// it every divide is unsigned and signed_div is ignored.
//
// state   | meaning
// IDLE    | waiting for start
// DIVZERO | divisor was zero, one cycle to form the fixed result
// ON      | 32 shift/subtract iterations, cnt_q counts 0..31
// DONE    | ready pulse, result valid
module div_unit (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave dif
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, DONE} state_t;

  state_t      state_q, state_d;
  logic [64:0] sh_q;      // {partial remainder[64:32], dividend/quotient[31:0]}
  logic [31:0] dvsr_q;
  logic [5:0]  cnt_q;
  logic [63:0] result_q;

  logic        go;
  logic [31:0] a_mag, b_mag;
  logic [64:0] shifted, step;
  logic [32:0] trial;
  logic [31:0] q_fix, r_fix;
  logic        unused_msb;

  // annul beats start when both arrive in IDLE
  assign go = (state_q == IDLE) && dif.start && !dif.annul;

`ifdef DIV_SIGNED_EN
  logic q_neg_q, r_neg_q;
  logic q_neg_d, r_neg_d;

  always_comb begin
    a_mag   = dif.a;
    b_mag   = dif.b;
    q_neg_d = 1'b0;
    r_neg_d = 1'b0;
    if (dif.signed_div) begin
      if (dif.a[31]) a_mag = -dif.a;
      if (dif.b[31]) b_mag = -dif.b;
      q_neg_d = dif.a[31] ^ dif.b[31];
      r_neg_d = dif.a[31];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (go) begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign q_fix = q_neg_q ? -step[31:0]  : step[31:0];
  assign r_fix = r_neg_q ? -step[63:32] : step[63:32];
`else
  logic unused_sd;

  assign unused_sd = dif.signed_div;
  assign a_mag     = dif.a;
  assign b_mag     = dif.b;
  assign q_fix     = step[31:0];
  assign r_fix     = step[63:32];
`endif

  // One restoring step: shift left, trial-subtract from the upper 33 bits,
  // keep the difference and shift in 1 when it did not borrow.
  always_comb begin
    shifted = {sh_q[63:0], 1'b0};
    trial   = shifted[64:32] - {1'b0, dvsr_q};
    step    = shifted;
    if (!trial[32]) step = {trial, shifted[31:1], 1'b1};
  end

  // remainder stays below 2^32, so the top bit is never read
  assign unused_msb = sh_q[64];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    dif.busy  = 1'b0;
    dif.ready = 1'b0;
    case (state_q)
      ON, DIVZERO: dif.busy  = 1'b1;
      DONE:        dif.ready = 1'b1;
      default: ;
    endcase
    if (dif.annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (dif.start) state_d = (dif.b == 32'd0) ? DIVZERO : ON;
        DIVZERO: state_d = DONE;
        ON:      if (cnt_q == 6'd31) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q     <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (go) begin
      cnt_q  <= '0;
      dvsr_q <= b_mag;
      // divide-by-zero keeps the raw dividend so it can become the remainder
      sh_q   <= {33'd0, (dif.b == 32'd0) ? dif.a : a_mag};
    end else if (state_q == ON) begin
      sh_q  <= step;
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == 6'd31 && !dif.annul) result_q <= {r_fix, q_fix};
    end else if (state_q == DIVZERO && !dif.annul) begin
      result_q <= {sh_q[31:0], 32'hFFFF_FFFF};
    end
  end

  assign dif.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit. Expected values are
// hand-computed; signed expectations switch on DIV_SIGNED_EN.
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] last_res;

  div_unit_if dif ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drive a start for one sampling edge, then scramble operands
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sd);
    @(negedge clk);
    dif.a = a; dif.b = b; dif.signed_div = sd; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.a = 32'hDEAD_BEEF; dif.b = 32'h0; dif.signed_div = ~sd;
  endtask

  // lat = cycle index of the ready pulse after the start edge, -1 if none
  task automatic wait_ready(input int budget, input int poke_at,
                            output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      dif.start = 1'b0;
      if (dif.ready === 1'b1) begin
        lat = k;
        if (dif.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (dif.busy !== 1'b1) busy_ok = 1'b0;
      if (k == poke_at) begin
        dif.a = 32'd9; dif.b = 32'd3; dif.signed_div = 1'b0; dif.start = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    int lat; bit bo;
    repeat (2) @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0 || dif.ready !== 1'b0 || dif.result !== 64'h0) begin
      failures++;
      $display("FAIL reset_init: busy=%b ready=%b result=%h want 0 0 0", dif.busy, dif.ready, dif.result);
    end
    @(negedge clk); rst = 1'b1;
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dif.busy !== 1'b0 || dif.ready !== 1'b0 || dif.result !== 64'h0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b ready=%b result=%h want 0 0 0", dif.busy, dif.ready, dif.result);
    end
    @(negedge clk); rst = 1'b1;
    wait_ready(45, 0, lat, bo);
    checks++;
    if (lat != -1) begin
      failures++;
      $display("FAIL reset_no_ready: ready at cycle %0d want none", lat);
    end
    last_res = 64'h0;
  endtask

  task automatic test_divu;
    int lat; bit bo;
    launch(32'd100, 32'd7, 1'b0);
    wait_ready(40, 0, lat, bo);
    checks++;
    if (lat != 33) begin failures++; $display("FAIL divu_latency: got %0d want 33", lat); end
    checks++;
    if (!bo) begin failures++; $display("FAIL divu_busy: busy not high for cycles 1-32 / low at ready"); end
    checks++;
    if (dif.result !== {32'd2, 32'd14}) begin
      failures++; $display("FAIL divu_result: got %h want %h", dif.result, {32'd2, 32'd14});
    end
    @(negedge clk);
    checks++;
    if (dif.ready !== 1'b0 || dif.result !== {32'd2, 32'd14}) begin
      failures++; $display("FAIL divu_after: ready=%b result=%h want 0 and held", dif.ready, dif.result);
    end
    last_res = {32'd2, 32'd14};
  endtask

  task automatic test_signed;
    int lat; bit bo;
    logic [63:0] exp1, exp2;
`ifdef DIV_SIGNED_EN
    exp1 = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
    exp2 = {32'h0000_0000, 32'h8000_0000};
`else
    exp1 = {32'h0000_0002, 32'h2492_4916};
    exp2 = {32'h8000_0000, 32'h0000_0000};
`endif
    launch(32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_ready(40, 0, lat, bo);
    checks++;
    if (lat != 33 || dif.result !== exp1) begin
      failures++; $display("FAIL signed_neg100_7: lat=%0d result=%h want 33 %h", lat, dif.result, exp1);
    end
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_ready(40, 0, lat, bo);
    checks++;
    if (lat != 33 || dif.result !== exp2) begin
      failures++; $display("FAIL signed_overflow: lat=%0d result=%h want 33 %h", lat, dif.result, exp2);
    end
    last_res = exp2;
  endtask

  task automatic test_divzero;
    int lat; bit bo;
    launch(32'h1234_5678, 32'd0, 1'b0);
    wait_ready(10, 0, lat, bo);
    checks++;
    if (lat != 2 || !bo) begin
      failures++; $display("FAIL divzero_latency: lat=%0d busy_ok=%b want 2 1", lat, bo);
    end
    checks++;
    if (dif.result !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
      failures++; $display("FAIL divzero_result: got %h want %h", dif.result, {32'h1234_5678, 32'hFFFF_FFFF});
    end
    launch(32'hFFFF_FF9C, 32'd0, 1'b1);
    wait_ready(10, 0, lat, bo);
    checks++;
    if (lat != 2 || dif.result !== {32'hFFFF_FF9C, 32'hFFFF_FFFF}) begin
      failures++; $display("FAIL divzero_signed: lat=%0d result=%h want 2 %h", lat, dif.result, {32'hFFFF_FF9C, 32'hFFFF_FFFF});
    end
    last_res = {32'hFFFF_FF9C, 32'hFFFF_FFFF};
  endtask

  task automatic test_annul;
    int lat; bit bo;
    launch(32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    dif.annul = 1'b1;
    @(posedge clk); #1 dif.annul = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0 || dif.ready !== 1'b0) begin
      failures++; $display("FAIL annul_idle: busy=%b ready=%b want 0 0", dif.busy, dif.ready);
    end
    wait_ready(40, 0, lat, bo);
    checks++;
    if (lat != -1 || dif.result !== last_res) begin
      failures++; $display("FAIL annul_no_ready: lat=%0d result=%h want none %h", lat, dif.result, last_res);
    end
    launch(32'd1000, 32'd3, 1'b0);
    wait_ready(40, 0, lat, bo);
    checks++;
    if (lat != 33 || dif.result !== {32'd1, 32'd333}) begin
      failures++; $display("FAIL annul_restart: lat=%0d result=%h want 33 %h", lat, dif.result, {32'd1, 32'd333});
    end
    @(negedge clk);
    dif.a = 32'd5; dif.b = 32'd1; dif.signed_div = 1'b0; dif.start = 1'b1; dif.annul = 1'b1;
    @(posedge clk); #1 dif.start = 1'b0; dif.annul = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0) begin failures++; $display("FAIL annul_start_busy: got %b want 0", dif.busy); end
    wait_ready(40, 0, lat, bo);
    checks++;
    if (lat != -1 || dif.result !== {32'd1, 32'd333}) begin
      failures++; $display("FAIL annul_start_none: lat=%0d result=%h want none %h", lat, dif.result, {32'd1, 32'd333});
    end
    last_res = {32'd1, 32'd333};
  endtask

  task automatic test_start_ignored;
    int lat; bit bo;
    launch(32'd100, 32'd7, 1'b0);
    wait_ready(40, 5, lat, bo);
    checks++;
    if (lat != 33 || !bo) begin
      failures++; $display("FAIL ignored_latency: lat=%0d busy_ok=%b want 33 1", lat, bo);
    end
    checks++;
    if (dif.result !== {32'd2, 32'd14}) begin
      failures++; $display("FAIL ignored_result: got %h want %h", dif.result, {32'd2, 32'd14});
    end
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0 || dif.ready !== 1'b0) begin
      failures++; $display("FAIL ignored_idle: busy=%b ready=%b want 0 0", dif.busy, dif.ready);
    end
  endtask

  task automatic test_signed_select;
    int lat; bit bo;
    logic [63:0] expv;
`ifdef DIV_SIGNED_EN
    expv = {32'hFFFF_FFFF, 32'h0000_0000};
`else
    expv = {32'h0000_0001, 32'h7FFF_FFFF};
`endif
    launch(32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_ready(40, 0, lat, bo);
    checks++;
    if (lat != 33 || dif.result !== expv) begin
      failures++; $display("FAIL signed_select: lat=%0d result=%h want 33 %h", lat, dif.result, expv);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_res = '0;
    rst = 1'b0;
    dif.a = '0; dif.b = '0; dif.signed_div = 1'b0; dif.start = 1'b0; dif.annul = 1'b0;
    test_reset();
    test_divu();
    test_signed();
    test_divzero();
    test_annul();
    test_start_ignored();
    test_signed_select();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
